// File: rtl/rf_pkg.sv
// Shared register-file definitions: data width, register count, index type
// and the write-port grant encoding used by the writeback arbiter.
package rf_pkg;

  localparam int RF_XLEN         = 64;
  localparam int RF_NREG         = 32;
  localparam int RF_AW           = $clog2(RF_NREG);
  localparam int RF_STARVE_LIMIT = 4;

  typedef logic [RF_AW-1:0] reg_idx_t;

  typedef enum logic {
    GRANT_PIPE = 1'b0,
    GRANT_MC   = 1'b1
  } grant_e;

  // True when an index names a real architectural register (not x0).
  function automatic logic idx_live(input logic [RF_AW-1:0] idx);
    return (idx != {RF_AW{1'b0}});
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: one bit per register owned by an in-flight
// long-latency op, issue-to-busy error flag and three-port decode lookup.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            i_set_valid,
  input  logic [AW-1:0]   i_set_rd,
  input  logic            i_clr_valid,
  input  logic [AW-1:0]   i_clr_rd,
  input  logic            i_id_valid,
  input  logic [AW-1:0]   i_id_rs1,
  input  logic [AW-1:0]   i_id_rs2,
  input  logic [AW-1:0]   i_id_rd,
  output logic [NREG-1:0] o_busy,
  output logic            o_sb_error,
  output logic            o_hazard
);

  logic [NREG-1:0] r_busy;
  logic            r_sb_error;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_clr_vec;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_err_evt;
  logic            w_rs1_busy;
  logic            w_rs2_busy;
  logic            w_rd_busy;

  // Decode set/clear requests into one-hot vectors; x0 never participates.
  always_comb begin
    w_set_vec = {NREG{1'b0}};
    w_clr_vec = {NREG{1'b0}};
    if (i_set_valid && (i_set_rd != {AW{1'b0}})) begin
      w_set_vec[i_set_rd] = 1'b1;
    end else begin
      w_set_vec = {NREG{1'b0}};
    end
    if (i_clr_valid && (i_clr_rd != {AW{1'b0}})) begin
      w_clr_vec[i_clr_rd] = 1'b1;
    end else begin
      w_clr_vec = {NREG{1'b0}};
    end
  end

  // Set is applied after clear so a same-register set/clear leaves the bit set;
  // issuing to a register that stays busy (no same-cycle clear) is an error.
  always_comb begin
    w_busy_nxt = (r_busy & ~w_clr_vec) | w_set_vec;
    w_err_evt  = |(w_set_vec & r_busy & ~w_clr_vec);
  end

  // Scoreboard state and sticky error flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy     <= {NREG{1'b0}};
      r_sb_error <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_sb_error <= r_sb_error | w_err_evt;
    end
  end

  // Decode lookup against registered state only: no bypass of this cycle's clear.
  always_comb begin
    w_rs1_busy = (i_id_rs1 != {AW{1'b0}}) & r_busy[i_id_rs1];
    w_rs2_busy = (i_id_rs2 != {AW{1'b0}}) & r_busy[i_id_rs2];
    w_rd_busy  = (i_id_rd  != {AW{1'b0}}) & r_busy[i_id_rd];
    o_hazard   = i_id_valid & (w_rs1_busy | w_rs2_busy | w_rd_busy);
  end

  assign o_busy     = r_busy;
  assign o_sb_error = r_sb_error;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the in-order writeback stage and
// one long-latency unit, with a starvation bound for the long-latency side
// and a busy-register scoreboard that stalls decode on RAW/WAW hazards.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN         = RF_XLEN,
  parameter int NREG         = RF_NREG,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT,
  parameter int AW           = $clog2(NREG)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            pipe_wb_valid,
  input  logic [AW-1:0]   pipe_wb_rd,
  input  logic [XLEN-1:0] pipe_wb_data,
  output logic            pipe_hold,
  input  logic            mc_issue_valid,
  input  logic [AW-1:0]   mc_issue_rd,
  input  logic            mc_wb_valid,
  input  logic [AW-1:0]   mc_wb_rd,
  input  logic [XLEN-1:0] mc_wb_data,
  output logic            mc_wb_ready,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  output logic            hazard_stall,
  output logic            rf_write_en,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic [NREG-1:0] busy_mask,
  output logic            sb_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]   r_starve_cnt;
  logic            w_pipe_req;
  logic            w_starved;
  grant_e          w_grant;
  logic            w_mc_accept;
  logic [NREG-1:0] w_busy;
  logic            w_sb_error;
  logic            w_hazard;

  // Grant selection: mc wins when the pipeline has no real write, or when mc
  // has already waited the full starvation budget.
  always_comb begin
    w_pipe_req = pipe_wb_valid & (pipe_wb_rd != {AW{1'b0}});
    w_starved  = (r_starve_cnt == SW'(STARVE_LIMIT));
    if (mc_wb_valid && (!w_pipe_req || w_starved)) begin
      w_grant = GRANT_MC;
    end else begin
      w_grant = GRANT_PIPE;
    end
    w_mc_accept = (w_grant == GRANT_MC) & ~Reset;
  end

  // Write-port mux and handshake outputs; everything is held at 0 in Reset.
  always_comb begin
    rf_write_en   = 1'b0;
    rf_rd         = {AW{1'b0}};
    rf_write_data = {XLEN{1'b0}};
    mc_wb_ready   = 1'b0;
    pipe_hold     = 1'b0;
    if (Reset) begin
      rf_write_en   = 1'b0;
      rf_rd         = {AW{1'b0}};
      rf_write_data = {XLEN{1'b0}};
      mc_wb_ready   = 1'b0;
      pipe_hold     = 1'b0;
    end else begin
      case (w_grant)
        GRANT_MC: begin
          rf_write_en   = (mc_wb_rd != {AW{1'b0}});
          rf_rd         = mc_wb_rd;
          rf_write_data = mc_wb_data;
          mc_wb_ready   = 1'b1;
          pipe_hold     = w_pipe_req;
        end
        GRANT_PIPE: begin
          rf_write_en   = w_pipe_req;
          rf_rd         = pipe_wb_rd;
          rf_write_data = pipe_wb_data;
          mc_wb_ready   = 1'b0;
          pipe_hold     = 1'b0;
        end
        default: begin
          rf_write_en   = 1'b0;
          rf_rd         = {AW{1'b0}};
          rf_write_data = {XLEN{1'b0}};
          mc_wb_ready   = 1'b0;
          pipe_hold     = 1'b0;
        end
      endcase
    end
  end

  // Count consecutive cycles a pending mc result is refused, saturating at the limit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_starve_cnt <= {SW{1'b0}};
    end else if (!mc_wb_valid || (w_grant == GRANT_MC)) begin
      r_starve_cnt <= {SW{1'b0}};
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_set_valid (mc_issue_valid),
    .i_set_rd    (mc_issue_rd),
    .i_clr_valid (w_mc_accept),
    .i_clr_rd    (mc_wb_rd),
    .i_id_valid  (id_valid),
    .i_id_rs1    (id_rs1),
    .i_id_rs2    (id_rs2),
    .i_id_rd     (id_rd),
    .o_busy      (w_busy),
    .o_sb_error  (w_sb_error),
    .o_hazard    (w_hazard)
  );

  // Scoreboard-derived outputs are forced to 0 while Reset is asserted.
  always_comb begin
    if (Reset) begin
      busy_mask    = {NREG{1'b0}};
      sb_error     = 1'b0;
      hazard_stall = 1'b0;
    end else begin
      busy_mask    = w_busy;
      sb_error     = w_sb_error;
      hazard_stall = w_hazard;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed test-plan scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int STARVE = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            pipe_wb_valid;
  logic [AW-1:0]   pipe_wb_rd;
  logic [XLEN-1:0] pipe_wb_data;
  logic            pipe_hold;
  logic            mc_issue_valid;
  logic [AW-1:0]   mc_issue_rd;
  logic            mc_wb_valid;
  logic [AW-1:0]   mc_wb_rd;
  logic [XLEN-1:0] mc_wb_data;
  logic            mc_wb_ready;
  logic            id_valid;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            hazard_stall;
  logic            rf_write_en;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_write_data;
  logic [NREG-1:0] busy_mask;
  logic            sb_error;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit m_busy [NREG];
  int m_starve;
  bit m_err;
  // model expectations for the current cycle
  bit              e_we, e_ready, e_hold, e_haz, e_err;
  logic [AW-1:0]   e_rd;
  logic [XLEN-1:0] e_data;
  logic [NREG-1:0] e_mask;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .STARVE_LIMIT(STARVE)) dut (
    .Clk(Clk), .Reset(Reset),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_hold(pipe_hold),
    .mc_issue_valid(mc_issue_valid), .mc_issue_rd(mc_issue_rd),
    .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd), .mc_wb_data(mc_wb_data),
    .mc_wb_ready(mc_wb_ready),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .hazard_stall(hazard_stall),
    .rf_write_en(rf_write_en), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .busy_mask(busy_mask), .sb_error(sb_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the grant/scoreboard rules and the model state.
  task automatic model_eval();
    bit preq, gmc;
    preq = pipe_wb_valid && (pipe_wb_rd != 0);
    gmc  = mc_wb_valid && (!preq || (m_starve == STARVE));
    e_we = 0; e_rd = 0; e_data = 0; e_ready = 0; e_hold = 0; e_haz = 0; e_mask = 0; e_err = 0;
    if (!Reset) begin
      if (gmc) begin
        e_ready = 1; e_hold = preq; e_we = (mc_wb_rd != 0); e_rd = mc_wb_rd; e_data = mc_wb_data;
      end else begin
        e_we = preq; e_rd = pipe_wb_rd; e_data = pipe_wb_data;
      end
      for (int i = 0; i < NREG; i++) e_mask[i] = m_busy[i];
      e_err = m_err;
      e_haz = id_valid && ((id_rs1 != 0 && m_busy[id_rs1]) ||
                           (id_rs2 != 0 && m_busy[id_rs2]) ||
                           (id_rd  != 0 && m_busy[id_rd]));
    end
  endtask

  task automatic model_compare();
    chk("rf_write_en", rf_write_en, e_we);
    if (e_we) begin
      chk("rf_rd", rf_rd, e_rd);
      chk("rf_write_data", rf_write_data, e_data);
    end
    chk("mc_wb_ready", mc_wb_ready, e_ready);
    chk("pipe_hold", pipe_hold, e_hold);
    chk("hazard_stall", hazard_stall, e_haz);
    chk("busy_mask", busy_mask, e_mask);
    chk("sb_error", sb_error, e_err);
  endtask

  // State update at the clock edge (inputs are stable until the next negedge).
  task automatic model_commit();
    bit cleared;
    if (Reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_starve = 0; m_err = 0;
    end else begin
      cleared = 0;
      if (e_ready && mc_wb_rd != 0) begin
        m_busy[mc_wb_rd] = 0;
        cleared = 1;
      end
      if (mc_issue_valid && mc_issue_rd != 0) begin
        if (m_busy[mc_issue_rd]) m_err = 1;
        if (cleared && mc_wb_rd == mc_issue_rd) m_err = m_err;
        m_busy[mc_issue_rd] = 1;
      end
      if (mc_wb_valid && !e_ready) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
      else m_starve = 0;
    end
  endtask

  // One clock cycle with model checking; called with inputs already driven at negedge.
  task automatic cyc();
    #1;
    model_eval();
    model_compare();
    @(posedge Clk);
    model_commit();
    @(negedge Clk);
  endtask

  task automatic idle();
    Reset = 0; pipe_wb_valid = 0; pipe_wb_rd = 0; pipe_wb_data = 0;
    mc_issue_valid = 0; mc_issue_rd = 0; mc_wb_valid = 0; mc_wb_rd = 0; mc_wb_data = 0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1;
    #1;
    chk("reset_we", rf_write_en, 0);
    chk("reset_mask", busy_mask, 0);
    cyc();
    Reset = 0;
  endtask

  task automatic starve_run(input logic [AW-1:0] mrd);
    pipe_wb_valid = 1; pipe_wb_rd = 3; pipe_wb_data = 64'h1111;
    mc_wb_valid = 1; mc_wb_rd = mrd; mc_wb_data = 64'h2222;
    for (int i = 0; i < STARVE; i++) begin
      #1 chk("starve_wait_ready", mc_wb_ready, 0);
      cyc();
    end
    #1;
    chk("starve_grant_ready", mc_wb_ready, 1);
    chk("starve_grant_hold", pipe_hold, 1);
    chk("starve_grant_rd", rf_rd, mrd);
    cyc();
    mc_wb_valid = 0;
    #1;
    chk("starve_pipe_lands_we", rf_write_en, 1);
    chk("starve_pipe_lands_rd", rf_rd, 3);
    cyc();
    idle();
  endtask

  initial begin
    logic [XLEN-1:0] rdata;
    bit hold_mc;
    idle();
    m_starve = 0; m_err = 0;
    @(negedge Clk);
    // reset: outputs held at 0 even with traffic present
    Reset = 1; pipe_wb_valid = 1; pipe_wb_rd = 5; mc_wb_valid = 1; mc_wb_rd = 6; id_valid = 1;
    #1;
    chk("rst_we", rf_write_en, 0);
    chk("rst_ready", mc_wb_ready, 0);
    chk("rst_mask", busy_mask, 0);
    cyc();
    idle();

    // pipe-only writes
    pipe_wb_valid = 1; pipe_wb_rd = 5; pipe_wb_data = 64'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pipe_only_we", rf_write_en, 1);
      chk("pipe_only_rd", rf_rd, 5);
      chk("pipe_only_data", rf_write_data, 64'hAA);
      chk("pipe_only_hold", pipe_hold, 0);
      chk("pipe_only_mask", busy_mask, 0);
      cyc();
    end
    idle();

    // RAW on x7
    mc_issue_valid = 1; mc_issue_rd = 7; cyc();
    mc_issue_valid = 0; id_valid = 1; id_rs1 = 1; id_rs2 = 7; id_rd = 2;
    #1 chk("raw_stall", hazard_stall, 1);
    cyc();
    mc_wb_valid = 1; mc_wb_rd = 7; mc_wb_data = 64'hDEAD_BEEF;
    #1;
    chk("raw_accept", mc_wb_ready, 1);
    chk("raw_no_bypass", hazard_stall, 1);
    cyc();
    mc_wb_valid = 0;
    #1;
    chk("raw_release", hazard_stall, 0);
    chk("raw_mask7", busy_mask[7], 0);
    cyc();
    idle();

    // starvation
    starve_run(5'd12);

    // same-cycle set/clear on x9
    mc_issue_valid = 1; mc_issue_rd = 9; cyc();
    mc_wb_valid = 1; mc_wb_rd = 9; cyc();
    idle();
    #1;
    chk("setclr_mask9", busy_mask[9], 1);
    chk("setclr_err", sb_error, 0);
    mc_wb_valid = 1; mc_wb_rd = 9; cyc();
    idle();

    // x0 handling
    mc_wb_valid = 1; mc_wb_rd = 0; mc_wb_data = 64'h55;
    #1;
    chk("x0_mc_ready", mc_wb_ready, 1);
    chk("x0_mc_we", rf_write_en, 0);
    cyc();
    idle();
    mc_issue_valid = 1; mc_issue_rd = 0; cyc();
    idle();
    #1 chk("x0_issue_mask", busy_mask, 0);
    pipe_wb_valid = 1; pipe_wb_rd = 0; mc_wb_valid = 1; mc_wb_rd = 4; mc_wb_data = 64'h44;
    id_valid = 1; id_rs1 = 0;
    #1;
    chk("x0_pipe_no_block", mc_wb_ready, 1);
    chk("x0_pipe_no_block_rd", rf_rd, 4);
    chk("x0_rs1_no_stall", hazard_stall, 0);
    cyc();
    idle();

    // duplicate issue sets sticky error
    mc_issue_valid = 1; mc_issue_rd = 11; cyc();
    cyc();
    idle();
    #1 chk("dup_issue_err", sb_error, 1);
    cyc();
    #1 chk("err_sticky", sb_error, 1);

    // reset mid-operation
    do_reset();
    mc_issue_valid = 1; mc_issue_rd = 7; cyc();
    mc_issue_rd = 10; cyc();
    mc_issue_valid = 0;
    pipe_wb_valid = 1; pipe_wb_rd = 3; mc_wb_valid = 1; mc_wb_rd = 20;
    for (int i = 0; i < 3; i++) cyc();
    #1 chk("midop_mask", busy_mask, 32'h0000_0480);
    Reset = 1; id_valid = 1; id_rs1 = 7;
    #1;
    chk("midop_rst_we", rf_write_en, 0);
    chk("midop_rst_ready", mc_wb_ready, 0);
    chk("midop_rst_hold", pipe_hold, 0);
    chk("midop_rst_haz", hazard_stall, 0);
    chk("midop_rst_mask", busy_mask, 0);
    cyc();
    idle();
    #1;
    chk("midop_after_mask", busy_mask, 0);
    chk("midop_after_err", sb_error, 0);
    starve_run(5'd21);

    // randomized traffic
    hold_mc = 0;
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(0, 59) == 0);
      pipe_wb_valid = ($urandom_range(0, 9) < 7);
      pipe_wb_rd = AW'($urandom_range(0, 15));
      rdata = {$urandom, $urandom};
      pipe_wb_data = rdata;
      if (!hold_mc) begin
        mc_wb_valid = ($urandom_range(0, 1) == 1);
        mc_wb_rd = AW'($urandom_range(0, 15));
        rdata = {$urandom, $urandom};
        mc_wb_data = rdata;
      end
      mc_issue_valid = ($urandom_range(0, 9) < 3);
      mc_issue_rd = AW'($urandom_range(0, 15));
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = AW'($urandom_range(0, 15));
      id_rs2 = AW'($urandom_range(0, 15));
      id_rd  = AW'($urandom_range(0, 15));
      cyc();
      hold_mc = mc_wb_valid && !e_ready && !Reset;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
